spi_device_interface: RTL and testbench

SPI_DEVICE_INTERFACE -- requirements
Module: spi_device_interface

---
 rtl/spi_device_interface.sv | 154 +++++++++++++++
 tb/tb_spi_device_interface.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_device_interface.sv
// rtl/spi_device_interface.sv - SPI mode 0 device with synchronised inputs, single-byte transmit buffer
// Receives MSB-first bytes on MOSI and returns buffered bytes on MISO, all timing in the clk domain.
module spi_device_interface (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       cs_start,
  output logic       cs_end,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       tx_data_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready
);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEL  = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] sck_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sck_d;
  logic       cs_d;
  logic [1:0] flush;
  logic [2:0] bit_cnt;
  logic       byte_done;
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] tx_buf;

  logic       sck_s;
  logic       cs_s;
  logic       mosi_s;
  logic       sck_rise;
  logic       sck_fall;
  logic       sel_active;
  logic       start_evt;
  logic       bit_fall;
  logic       boundary;
  logic       xfer;
  logic [7:0] rx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      flush     <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_d     <= sck_sync[1];
      cs_d      <= cs_sync[1];
      flush     <= {flush[0], 1'b1};
    end
  end

  assign sck_s      = sck_sync[1];
  assign cs_s       = cs_sync[1];
  assign mosi_s     = mosi_sync[1];
  assign sck_rise   = sck_s && !sck_d;
  assign sck_fall   = !sck_s && sck_d;
  // A rising CS in the same cycle as an SCK edge masks the edge.
  assign sel_active = (state == ST_SEL) && !cs_s;
  assign start_evt  = (state == ST_IDLE) && cs_d && !cs_s;
  assign bit_fall   = sel_active && sck_fall;
  assign boundary   = bit_fall && byte_done;
  assign xfer       = start_evt || boundary;
  assign rx_next    = {rx_shift[6:0], mosi_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_ARM;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      cs_start    <= 1'b0;
      cs_end      <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= 8'h00;
      tx_ready    <= 1'b1;
      bit_cnt     <= 3'd0;
      byte_done   <= 1'b0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'h00;
      tx_buf      <= 8'h00;
    end else begin
      cs_start <= 1'b0;
      cs_end   <= 1'b0;
      rx_valid <= 1'b0;
      spi_miso <= sel_active ? tx_shift[7] : 1'b0;

      case (state)
        // After reset, CS must be seen high through the flushed synchronizer before a new select.
        ST_ARM: begin
          if (flush[1] && cs_s) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (start_evt) begin
            state       <= ST_SEL;
            cs_start    <= 1'b1;
            spi_miso_oe <= 1'b1;
            bit_cnt     <= 3'd0;
            byte_done   <= 1'b0;
          end
        end
        ST_SEL: begin
          if (cs_s) begin
            state       <= ST_IDLE;
            cs_end      <= 1'b1;
            spi_miso_oe <= 1'b0;
            bit_cnt     <= 3'd0;
            byte_done   <= 1'b0;
          end else if (sck_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data   <= rx_next;
              rx_valid  <= 1'b1;
              byte_done <= 1'b1;
            end
          end else if (sck_fall) begin
            byte_done <= 1'b0;
          end
        end
        default: state <= ST_ARM;
      endcase

      // A load coinciding with a transfer lands in the just-emptied buffer.
      if (xfer) begin
        tx_shift <= tx_ready ? 8'h00 : tx_buf;
        tx_ready <= !tx_data_valid;
        if (tx_data_valid) tx_buf <= tx_data;
      end else begin
        if (bit_fall) tx_shift <= {tx_shift[6:0], 1'b0};
        if (tx_data_valid && tx_ready) begin
          tx_buf   <= tx_data;
          tx_ready <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_device_interface.sv
// tb/tb_spi_device_interface.sv - randomized bench for spi_device_interface
// The host drives SCK at clk/8; expectations come from a transaction-level buffer model.
module tb_spi_device_interface;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       cs_start;
  logic       cs_end;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_data_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;

  spi_device_interface dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .cs_start(cs_start), .cs_end(cs_end),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_data_valid(tx_data_valid), .tx_data(tx_data),
    .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         n_cs_start = 0;
  int         n_cs_end = 0;
  logic [7:0] rx_q[$];
  logic [7:0] host_mosi[$];
  int         load_plan[$];
  logic       m_full = 1'b0;
  logic [7:0] m_buf = 8'h00;
  logic [7:0] m_last_rx = 8'h00;

  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (cs_start) n_cs_start++;
    if (cs_end) n_cs_end++;
  end

  task automatic model_load(input logic [7:0] b);
    if (!m_full) begin
      m_buf  = b;
      m_full = 1'b1;
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_data_valid = 1'b1;
    model_load(b);
    @(negedge clk);
    tx_data_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input int nbits, input int rst_after);
    logic [7:0] slots[$];
    logic [7:0] got[$];
    logic [7:0] cur;
    int sc0, se0, bi, bj, nfull;
    rx_q.delete();
    sc0 = n_cs_start;
    se0 = n_cs_end;
    cur = 8'h00;
    slots.push_back(m_full ? m_buf : 8'h00);
    m_full = 1'b0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (spi_miso_oe !== 1'b1 || n_cs_start != sc0 + 1) begin
      bad++;
      $display("FAIL %s select: oe=%b starts=%0d, want oe=1 starts=%0d", name, spi_miso_oe, n_cs_start - sc0, 1);
    end
    for (int b = 0; b < nbits; b++) begin
      bi = b / 8;
      bj = b % 8;
      spi_mosi = host_mosi[bi][7-bj];
      for (int k = 0; k < HALF; k++) begin
        @(negedge clk);
        if (k == 0 && bj == 2 && bi < load_plan.size() && load_plan[bi] >= 0) begin
          tx_data = 8'(load_plan[bi]);
          tx_data_valid = 1'b1;
          model_load(tx_data);
        end else begin
          tx_data_valid = 1'b0;
        end
      end
      cur = {cur[6:0], spi_miso};
      spi_sck = 1'b1;
      if (bj == 7) got.push_back(cur);
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
      if (bj == 7) begin
        slots.push_back(m_full ? m_buf : 8'h00);
        m_full = 1'b0;
      end
      if (rst_after == b + 1) begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_full = 1'b0;
        m_last_rx = 8'h00;
        repeat (2) @(negedge clk);
        total++;
        if ({spi_miso, spi_miso_oe, cs_start, cs_end, rx_valid, tx_ready} !== 6'b000001) begin
          bad++;
          $display("FAIL %s reset_flags: got=%b want=000001", name, {spi_miso, spi_miso_oe, cs_start, cs_end, rx_valid, tx_ready});
        end
        total++;
        if (rx_data !== 8'h00) begin
          bad++;
          $display("FAIL %s reset_rx_data: got=%h want=00", name, rx_data);
        end
        rst = 1'b0;
        spi_mosi = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (n_cs_start != sc0 + 1 || spi_miso_oe !== 1'b0) begin
          bad++;
          $display("FAIL %s post_reset_idle: starts=%0d oe=%b want starts=1 oe=0", name, n_cs_start - sc0, spi_miso_oe);
        end
        spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
        total++;
        if (n_cs_end != se0 || rx_q.size() != 0) begin
          bad++;
          $display("FAIL %s reset_no_pulses: ends=%0d rx=%0d want 0 0", name, n_cs_end - se0, rx_q.size());
        end
        return;
      end
    end
    repeat (3) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    nfull = nbits / 8;
    total++;
    if (n_cs_end != se0 + 1) begin
      bad++;
      $display("FAIL %s cs_end_count: got=%0d want=1", name, n_cs_end - se0);
    end
    total++;
    if (rx_q.size() != nfull) begin
      bad++;
      $display("FAIL %s rx_count: got=%0d want=%0d", name, rx_q.size(), nfull);
    end
    for (int i = 0; i < nfull; i++) begin
      if (i < rx_q.size()) begin
        total++;
        if (rx_q[i] !== host_mosi[i]) begin
          bad++;
          $display("FAIL %s rx_byte%0d: got=%h want=%h", name, i, rx_q[i], host_mosi[i]);
        end
      end
      total++;
      if (got[i] !== slots[i]) begin
        bad++;
        $display("FAIL %s miso_byte%0d: got=%h want=%h", name, i, got[i], slots[i]);
      end
    end
    if (nfull > 0) m_last_rx = host_mosi[nfull-1];
    total++;
    if (rx_data !== m_last_rx) begin
      bad++;
      $display("FAIL %s rx_data_held: got=%h want=%h", name, rx_data, m_last_rx);
    end
    total++;
    if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin
      bad++;
      $display("FAIL %s deselect: oe=%b miso=%b want 0 0", name, spi_miso_oe, spi_miso);
    end
    total++;
    if (tx_ready !== !m_full) begin
      bad++;
      $display("FAIL %s tx_ready_after: got=%b want=%b", name, tx_ready, !m_full);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({spi_miso, spi_miso_oe, cs_start, cs_end, rx_valid, tx_ready} !== 6'b000001 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: flags=%b rx_data=%h want flags=000001 rx_data=00",
               {spi_miso, spi_miso_oe, cs_start, cs_end, rx_valid, tx_ready}, rx_data);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    load_byte(8'hA5);
    total++;
    if (tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_load_ready: got=%b want=0", tx_ready);
    end
    host_mosi = '{8'h3C};
    load_plan = '{-1};
    run_frame("basic", 8, 0);
  endtask

  task automatic test_back_to_back;
    load_byte(8'h01);
    host_mosi = '{8'($urandom), 8'($urandom), 8'($urandom)};
    load_plan = '{2, 3, -1};
    run_frame("back_to_back", 24, 0);
  endtask

  task automatic test_no_tx;
    host_mosi = '{8'($urandom), 8'($urandom)};
    load_plan = '{-1, -1};
    run_frame("no_tx", 16, 0);
  endtask

  task automatic test_cs_abort;
    load_byte(8'($urandom));
    host_mosi = '{8'($urandom)};
    load_plan = '{int'($urandom_range(0, 255))};
    run_frame("cs_abort", 5, 0);
    host_mosi = '{8'($urandom)};
    load_plan = '{-1};
    run_frame("after_abort", 8, 0);
  endtask

  task automatic test_tx_ignore;
    load_byte(8'h5A);
    load_byte(8'hC3);
    total++;
    if (tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL ignore_ready: got=%b want=0", tx_ready);
    end
    host_mosi = '{8'($urandom)};
    load_plan = '{-1};
    run_frame("tx_ignore", 8, 0);
  endtask

  task automatic test_reset_mid;
    load_byte(8'($urandom));
    host_mosi = '{8'($urandom)};
    load_plan = '{-1};
    run_frame("reset_mid", 8, 4);
    load_byte(8'($urandom));
    host_mosi = '{8'($urandom)};
    run_frame("after_reset", 8, 0);
  endtask

  task automatic test_random;
    int nb, extra;
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) load_byte(8'($urandom));
      nb = $urandom_range(1, 3);
      extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
      host_mosi.delete();
      load_plan.delete();
      for (int i = 0; i < nb + 1; i++) begin
        host_mosi.push_back(8'($urandom));
        load_plan.push_back(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : -1);
      end
      run_frame("random", nb * 8 + extra, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_no_tx();
    test_cs_abort();
    test_tx_ignore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
